// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory responder for an LSU.
//
// Accepts one load/store request at a time and answers it LATENCY cycles
// after the accept edge. Stores are written in the accept cycle. Loads are
// read in the cycle before the response is presented and are sign- or
// zero-extended. Memory is little-endian, word-indexed, and wraps modulo
// DEPTH_WORDS*4 bytes. A mispredict flushes an in-flight load. Stores and
// their acknowledges are unaffected.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses report resp_err, with no write
//               and resp_data=0.
//   undefined : misaligned addresses are forced to natural alignment.
//
// Parameters:
//   DEPTH_WORDS : memory size in 32-bit words (power of two, >= 2)
//   LATENCY     : cycles from accept to first resp_valid (1..15)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake
//   req_we, req_addr,
//   req_wdata, req_size,
//   req_unsigned, req_tag      request fields (size 0=B 1=H 2=W 3=illegal)
//   mispredict                 flush of in-flight loads
//   resp_valid / resp_ready    response handshake
//   resp_data, resp_tag,
//   resp_is_store, resp_err    response fields (all registered)

module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [4:0]  req_tag,
    input  logic        mispredict,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        resp_is_store,
    output logic        resp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state;
    logic [3:0]        count;
    logic              lat_we;
    logic              lat_unsigned;
    logic              lat_err;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic [IdxW-1:0]   lat_idx;
    logic [4:0]        lat_tag;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic [31:0]       req_addr_al;
    logic              req_err;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    logic [IdxW-1:0]   rd_idx;
    logic [1:0]        rd_off;
    logic [1:0]        rd_size;
    logic              rd_unsigned;
    logic              rd_we;
    logic              rd_err;
    logic [4:0]        rd_tag;
    logic [31:0]       rd_word;
    logic [31:0]       rd_lane;
    logic [31:0]       rd_data;

    // Address bits above the memory index are intentionally ignored (wrap).
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:IdxW+2], req_addr_al[31:IdxW+2]};

    assign accept = req_valid && req_ready;

    // Error detection and address alignment.
    always_comb begin
        req_addr_al = req_addr;
        req_err     = (req_size == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (req_size == 2'd1 && req_addr[0]) begin
            req_err = 1'b1;
        end
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
`else
        if (req_size == 2'd1) begin
            req_addr_al[0] = 1'b0;
        end
        if (req_size == 2'd2) begin
            req_addr_al[1:0] = 2'b00;
        end
`endif
    end

    // Store byte enables; data is replicated so each lane sees its bytes.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        case (req_size)
            2'd0: begin
                wr_be   = 4'b0001 << req_addr_al[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = req_addr_al[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
            default: ;
        endcase
        if (req_err) begin
            wr_be = 4'b0000;
        end
    end

    // Memory is not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && accept && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[req_addr_al[IdxW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // In IDLE the read uses the live request (LATENCY==1 path), otherwise the
    // latched request.
    always_comb begin
        if (state == StIdle) begin
            rd_idx      = req_addr_al[IdxW+1:2];
            rd_off      = req_addr_al[1:0];
            rd_size     = req_size;
            rd_unsigned = req_unsigned;
            rd_we       = req_we;
            rd_err      = req_err;
            rd_tag      = req_tag;
        end else begin
            rd_idx      = lat_idx;
            rd_off      = lat_off;
            rd_size     = lat_size;
            rd_unsigned = lat_unsigned;
            rd_we       = lat_we;
            rd_err      = lat_err;
            rd_tag      = lat_tag;
        end
    end

    always_comb begin
        rd_word = mem[rd_idx];
        rd_lane = rd_word >> {rd_off, 3'b000};
        case (rd_size)
            2'd0:    rd_data = rd_unsigned ? {24'h0, rd_lane[7:0]}
                                           : {{24{rd_lane[7]}}, rd_lane[7:0]};
            2'd1:    rd_data = rd_unsigned ? {16'h0, rd_lane[15:0]}
                                           : {{16{rd_lane[15]}}, rd_lane[15:0]};
            default: rd_data = rd_word;
        endcase
        if (rd_err || rd_we) begin
            rd_data = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            count         <= 4'd0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= 32'h0;
            resp_tag      <= 5'd0;
            resp_is_store <= 1'b0;
            resp_err      <= 1'b0;
            lat_we        <= 1'b0;
            lat_unsigned  <= 1'b0;
            lat_err       <= 1'b0;
            lat_size      <= 2'd0;
            lat_off       <= 2'd0;
            lat_idx       <= '0;
            lat_tag       <= 5'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready    <= 1'b0;
                        lat_we       <= req_we;
                        lat_unsigned <= req_unsigned;
                        lat_err      <= req_err;
                        lat_size     <= req_size;
                        lat_off      <= req_addr_al[1:0];
                        lat_idx      <= req_addr_al[IdxW+1:2];
                        lat_tag      <= req_tag;
                        count        <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state         <= StResp;
                            resp_valid    <= 1'b1;
                            resp_data     <= rd_data;
                            resp_tag      <= rd_tag;
                            resp_is_store <= rd_we;
                            resp_err      <= rd_err;
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mispredict && !lat_we) begin
                        state     <= StIdle;
                        req_ready <= 1'b1;
                        count     <= 4'd0;
                    end else if (count <= 4'd1) begin
                        // Counter reaches 0 on this edge: present the response.
                        state         <= StResp;
                        count         <= 4'd0;
                        resp_valid    <= 1'b1;
                        resp_data     <= rd_data;
                        resp_tag      <= rd_tag;
                        resp_is_store <= rd_we;
                        resp_err      <= rd_err;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                StResp: begin
                    if ((mispredict && !lat_we) || resp_ready) begin
                        state         <= StIdle;
                        req_ready     <= 1'b1;
                        resp_valid    <= 1'b0;
                        resp_data     <= 32'h0;
                        resp_tag      <= 5'd0;
                        resp_is_store <= 1'b0;
                        resp_err      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// response when a request is issued; the monitor pops and compares on every
// response handshake, and checks latency, stability under backpressure and
// that req_ready stays low while a response is pending.

module tb_data_mem_responder;

    localparam int unsigned Depth = 64;
    localparam int unsigned Lat   = 2;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        is_store;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_tag;
    logic        mispredict;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_is_store;
    logic        resp_err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   accept_edge = 0;

    data_mem_responder #(
        .DEPTH_WORDS(Depth),
        .LATENCY    (Lat)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_tag      (req_tag),
        .mispredict   (mispredict),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag),
        .resp_is_store(resp_is_store),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit          seen = 0;
        logic [31:0] s_data;
        logic [4:0]  s_tag;
        logic        s_st;
        logic        s_err;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp_valid", {31'h0, resp_valid}, 32'h0);
                end else begin
                    if (!seen) begin
                        seen   = 1;
                        s_data = resp_data;
                        s_tag  = resp_tag;
                        s_st   = resp_is_store;
                        s_err  = resp_err;
                        chk("latency", 32'(cyc + 1 - accept_edge), 32'(Lat));
                    end else begin
                        chk("stable_data", resp_data, s_data);
                        chk("stable_tag", {27'h0, resp_tag}, {27'h0, s_tag});
                        chk("stable_flags", {30'h0, resp_is_store, resp_err},
                            {30'h0, s_st, s_err});
                    end
                    chk("req_ready_low_in_resp", {31'h0, req_ready}, 32'h0);
                    if (resp_ready) begin
                        e = sb.pop_front();
                        chk("resp_data", resp_data, e.data);
                        chk("resp_tag", {27'h0, resp_tag}, {27'h0, e.tag});
                        chk("resp_is_store", {31'h0, resp_is_store}, {31'h0, e.is_store});
                        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [4:0] tag,
                        input bit push, input logic [31:0] edata, input logic eerr);
        bit ok = 0;
        if (push) sb.push_back('{tag: tag, data: edata, is_store: we, err: eerr});
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_tag      = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                accept_edge = cyc + 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [4:0] tag,
                        input logic [31:0] edata, input logic eerr);
        send(we, addr, wdata, size, uns, tag, 1, edata, eerr);
        drain();
    endtask

    task automatic chk_idle_outputs(input string name, input logic exp_ready);
        chk({name, "_req_ready"}, {31'h0, req_ready}, {31'h0, exp_ready});
        chk({name, "_resp"}, {resp_data[31:0]}, 32'h0);
        chk({name, "_flags"}, {25'h0, resp_valid, resp_tag, resp_is_store, resp_err}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'd2; req_unsigned = 1'b0; req_tag = 5'd0;
        mispredict = 1'b0; resp_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset", 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_before_first_edge", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;

        // Word store and load back.
        xfer(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 5'd1, 32'h0, 0);
        xfer(0, 32'h10, 32'h0, 2'd2, 0, 5'd2, 32'hDEADBEEF, 0);

        // Byte store into a known word, signed/unsigned loads, neighbours intact.
        xfer(1, 32'h20, 32'h11223344, 2'd2, 0, 5'd3, 32'h0, 0);
        xfer(1, 32'h21, 32'hAAAAAA80, 2'd0, 0, 5'd4, 32'h0, 0);
        xfer(0, 32'h21, 32'h0, 2'd0, 0, 5'd5, 32'hFFFFFF80, 0);
        xfer(0, 32'h21, 32'h0, 2'd0, 1, 5'd6, 32'h00000080, 0);
        xfer(0, 32'h20, 32'h0, 2'd2, 0, 5'd8, 32'h11228044, 0);

        // Upper half store and loads.
        xfer(1, 32'h22, 32'h1234BEEF, 2'd1, 0, 5'd10, 32'h0, 0);
        xfer(0, 32'h22, 32'h0, 2'd1, 0, 5'd11, 32'hFFFFBEEF, 0);
        xfer(0, 32'h22, 32'h0, 2'd1, 1, 5'd12, 32'h0000BEEF, 0);
        xfer(0, 32'h20, 32'h0, 2'd2, 0, 5'd13, 32'hBEEF8044, 0);

        // Misaligned half load at 0x13.
`ifdef DMEM_MISALIGN_CHECK_EN
        xfer(0, 32'h13, 32'h0, 2'd1, 0, 5'd14, 32'h0, 1);
`else
        xfer(0, 32'h13, 32'h0, 2'd1, 0, 5'd14, 32'hFFFFDEAD, 0);
`endif

        // Illegal size: no write, error acknowledge.
        xfer(1, 32'h10, 32'h00000000, 2'd3, 0, 5'd15, 32'h0, 1);
        xfer(0, 32'h10, 32'h0, 2'd2, 0, 5'd16, 32'hDEADBEEF, 0);

        // Load flushed by mispredict one cycle after accept.
        send(0, 32'h10, 32'h0, 2'd2, 0, 5'd7, 0, 32'h0, 0);
        mispredict = 1'b1;
        @(posedge clk); #1;
        mispredict = 1'b0;
        @(negedge clk);
        chk("flush_ready", {31'h0, req_ready}, 32'h1);
        chk("flush_no_valid", {31'h0, resp_valid}, 32'h0);
        repeat (6) @(posedge clk);
        #1;

        // Store survives mispredict; ack delivered and data written.
        send(1, 32'h30, 32'hCAFEF00D, 2'd2, 0, 5'd7, 1, 32'h0, 0);
        mispredict = 1'b1;
        @(posedge clk); #1;
        mispredict = 1'b0;
        drain();
        xfer(0, 32'h30, 32'h0, 2'd2, 0, 5'd17, 32'hCAFEF00D, 0);

        // Backpressure: resp_ready low for 5 cycles in RESP.
        resp_ready = 1'b0;
        send(0, 32'h20, 32'h0, 2'd2, 0, 5'd9, 1, 32'hBEEF8044, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        drain();

        // Reset mid-WAIT: response abandoned, outputs cleared.
        send(0, 32'h10, 32'h0, 2'd2, 0, 5'd18, 0, 32'h0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midwait_reset", 1'b0);
        @(negedge clk);
        chk_idle_outputs("post_reset", 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Memory kept across reset, and address wrap.
        xfer(0, 32'h10, 32'h0, 2'd2, 0, 5'd19, 32'hDEADBEEF, 0);
        xfer(1, 32'h0, 32'h5A5AA5A5, 2'd2, 0, 5'd20, 32'h0, 0);
        xfer(0, 32'(Depth * 4), 32'h0, 2'd2, 0, 5'd21, 32'h5A5AA5A5, 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
